tm1638_responder: RTL and testbench

Synthesizable TM1638 device-side model. It is the responder end of the 3-wire STB/CLK/DIO bus that our TM1638 byte shifter drives.
It decodes data, address and display-control commands, holds 16-byte display RAM, and returns a 32-bit key-scan snapshot on read commands, LSB first.
It is used for on-board panel emulation and for closed-loop verification of the bus master.

---
 rtl/tm1638_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes the STB/CLK/DIO command stream,
// keeps a 16-byte display RAM, and shifts a latched key snapshot back to the
// bus master on read frames (LSB first).
module tm1638_responder #(
   parameter int SYNC_STAGES = 2   // must be 2 or more
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stb,
   input  logic        sclk,
   input  logic        dio_in,
   output logic        dio_out,
   output logic        dio_oe,
   input  logic [31:0] keys,
   input  logic [3:0]  ram_raddr,
   output logic [7:0]  ram_rdata,
   output logic        display_on,
   output logic [2:0]  brightness,
   output logic        disp_upd
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WDATA,
      S_RDATA,
      S_IGNORE
   } state_t;

   // Synchronizer chains; bus lines idle high, so the chains reset high.
   logic [SYNC_STAGES-1:0] stb_sync_reg;
   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] dio_sync_reg;
   logic                   stb_d_reg;
   logic                   sclk_d_reg;

   logic stb_s;
   logic sclk_s;
   logic dio_s;
   logic stb_rise;
   logic stb_fall;
   logic sclk_rise;
   logic sclk_fall;

   state_t      state_reg;
   state_t      state_next;
   logic [2:0]  bitcnt_reg;
   logic [6:0]  shift_reg;
   logic [2:0]  idx_reg;
   logic [3:0]  ptr_reg;
   logic        mode_fixed_reg;
   logic [31:0] snap_reg;
   logic [7:0]  ram_reg [16];
   logic [7:0]  ram_rdata_reg;
   logic        display_on_reg;
   logic [2:0]  brightness_reg;
   logic        disp_upd_reg;
   logic        dio_out_reg;
   logic        dio_oe_reg;

   logic       byte_done;
   logic [7:0] byte_val;
   logic       ram_we;
   logic       ptr_load;
   logic       mode_we;
   logic       snap_we;
   logic       ctrl_we;
   logic       idx_inc;

   // Shift each bus input through its synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_sync_reg  <= '1;
         sclk_sync_reg <= '1;
         dio_sync_reg  <= '1;
      end else begin
         stb_sync_reg  <= {stb_sync_reg[SYNC_STAGES-2:0], stb};
         sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
         dio_sync_reg  <= {dio_sync_reg[SYNC_STAGES-2:0], dio_in};
      end
   end

   assign stb_s  = stb_sync_reg[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
   assign dio_s  = dio_sync_reg[SYNC_STAGES-1];

   // One-cycle delayed copies for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_d_reg  <= 1'b1;
         sclk_d_reg <= 1'b1;
      end else begin
         stb_d_reg  <= stb_s;
         sclk_d_reg <= sclk_s;
      end
   end

   assign stb_rise  = stb_s & ~stb_d_reg;
   assign stb_fall  = ~stb_s & stb_d_reg;
   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;

   // The completed byte is the seven stored bits plus the bit arriving now.
   assign byte_val  = {dio_s, shift_reg};
   assign byte_done = (state_reg != S_IDLE) && sclk_rise && (bitcnt_reg == 3'd7);

   // Frame state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and per-byte action strobes; strobe edges take priority so a
   // byte finishing as stb rises is dropped.
   always_comb begin
      state_next = state_reg;
      ram_we     = 1'b0;
      ptr_load   = 1'b0;
      mode_we    = 1'b0;
      snap_we    = 1'b0;
      ctrl_we    = 1'b0;
      idx_inc    = 1'b0;
      if (stb_rise) begin
         state_next = S_IDLE;
      end else if (stb_fall) begin
         state_next = S_CMD;
      end else if (byte_done) begin
         case (state_reg)
            S_CMD: begin
               case (byte_val[7:6])
                  2'b01: begin
                     mode_we = 1'b1;
                     if (byte_val[1]) begin
                        snap_we    = 1'b1;
                        state_next = S_RDATA;
                     end else begin
                        state_next = S_IGNORE;
                     end
                  end
                  2'b11: begin
                     ptr_load   = 1'b1;
                     state_next = S_WDATA;
                  end
                  2'b10: begin
                     ctrl_we    = 1'b1;
                     state_next = S_IGNORE;
                  end
                  default: begin
                     state_next = S_IGNORE;
                  end
               endcase
            end
            S_WDATA: begin
               ram_we = 1'b1;
            end
            S_RDATA: begin
               idx_inc = (idx_reg < 3'd4);
            end
            default: begin
            end
         endcase
      end
   end

   // Bit counter and LSB-first input shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt_reg <= 3'd0;
         shift_reg  <= 7'd0;
      end else if (stb_rise || stb_fall) begin
         bitcnt_reg <= 3'd0;
      end else if ((state_reg != S_IDLE) && sclk_rise) begin
         bitcnt_reg <= bitcnt_reg + 3'd1;
         shift_reg  <= {dio_s, shift_reg[6:1]};
      end
   end

   // Write pointer and addressing mode; the mode persists across frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg        <= 4'd0;
         mode_fixed_reg <= 1'b0;
      end else begin
         if (mode_we) begin
            mode_fixed_reg <= byte_val[2];
         end
         if (ptr_load) begin
            ptr_reg <= byte_val[3:0];
         end else if (ram_we && !mode_fixed_reg) begin
            ptr_reg <= ptr_reg + 4'd1;
         end
      end
   end

   // Key snapshot and read byte index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_reg <= 32'd0;
         idx_reg  <= 3'd0;
      end else if (snap_we) begin
         snap_reg <= keys;
         idx_reg  <= 3'd0;
      end else if (idx_inc) begin
         idx_reg <= idx_reg + 3'd1;
      end
   end

   // Display RAM with registered read; a same-cycle write is not forwarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            ram_reg[i] <= 8'h00;
         end
         ram_rdata_reg <= 8'h00;
      end else begin
         if (ram_we) begin
            ram_reg[ptr_reg] <= byte_val;
         end
         ram_rdata_reg <= ram_reg[ram_raddr];
      end
   end

   // Display control settings and the update pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display_on_reg <= 1'b0;
         brightness_reg <= 3'd0;
         disp_upd_reg   <= 1'b0;
      end else begin
         if (ctrl_we) begin
            display_on_reg <= byte_val[3];
            brightness_reg <= byte_val[2:0];
         end
         disp_upd_reg <= ram_we | ctrl_we;
      end
   end

   // Drive read data on sclk falls; release the bus after four bytes or at any frame edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dio_out_reg <= 1'b1;
         dio_oe_reg  <= 1'b0;
      end else if (stb_rise || stb_fall) begin
         dio_out_reg <= 1'b1;
         dio_oe_reg  <= 1'b0;
      end else if ((state_reg == S_RDATA) && sclk_fall) begin
         if (idx_reg < 3'd4) begin
            dio_out_reg <= snap_reg[{idx_reg[1:0], bitcnt_reg}];
            dio_oe_reg  <= 1'b1;
         end else begin
            dio_out_reg <= 1'b1;
            dio_oe_reg  <= 1'b0;
         end
      end
   end

   assign dio_out    = dio_out_reg;
   assign dio_oe     = dio_oe_reg;
   assign ram_rdata  = ram_rdata_reg;
   assign display_on = display_on_reg;
   assign brightness = brightness_reg;
   assign disp_upd   = disp_upd_reg;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: drives TM1638 frames as a bus master and
// compares against a byte-level behavioural model of the device.
module tb_tm1638_responder;

   localparam int SS = 2;
   localparam int PH = SS + 4;   // clk cycles per sclk phase

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b1;
   logic        sclk = 1'b1;
   logic        dio_in = 1'b1;
   logic [31:0] keys = 32'd0;
   logic [3:0]  ram_raddr = 4'd0;
   logic        dio_out;
   logic        dio_oe;
   logic [7:0]  ram_rdata;
   logic        display_on;
   logic [2:0]  brightness;
   logic        disp_upd;

   tm1638_responder #(.SYNC_STAGES(SS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stb        (stb),
      .sclk       (sclk),
      .dio_in     (dio_in),
      .dio_out    (dio_out),
      .dio_oe     (dio_oe),
      .keys       (keys),
      .ram_raddr  (ram_raddr),
      .ram_rdata  (ram_rdata),
      .display_on (display_on),
      .brightness (brightness),
      .disp_upd   (disp_upd)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int upd_cnt = 0;
   int n_trans = 0;

   // Count disp_upd high cycles; a stretched pulse shows up as extra counts.
   always @(posedge clk) begin
      if (!rst_n) upd_cnt <= 0;
      else if (disp_upd) upd_cnt <= upd_cnt + 1;
   end

   // Reference model state
   logic [7:0] m_ram [16];
   bit         m_fixed;
   bit         m_on;
   logic [2:0] m_bright;
   int         m_upd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      m_fixed = 0; m_on = 0; m_bright = 3'd0; m_upd = 0;
   endtask

   // Effect of one complete frame on device state, by command class.
   task automatic model_frame(input logic [7:0] q[$]);
      int p;
      logic [7:0] c;
      if (q.size() == 0) return;
      c = q[0];
      if (c[7:6] == 2'b01) begin
         m_fixed = c[2];
      end else if (c[7:6] == 2'b11) begin
         p = int'(c[3:0]);
         for (int k = 1; k < q.size(); k++) begin
            m_ram[p] = q[k];
            m_upd++;
            if (!m_fixed) p = (p + 1) % 16;
         end
      end else if (c[7:6] == 2'b10) begin
         m_on = c[3];
         m_bright = c[2:0];
         m_upd++;
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Send (or receive) nbits of one byte, LSB first; dio sampled just before each rise.
   task automatic bus_byte(input logic [7:0] b, input int nbits,
                           output logic [7:0] rx, output logic [7:0] oe);
      rx = 8'hFF;
      oe = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b0;
         dio_in = b[i];
         wait_clk(PH);
         rx[i] = dio_out;
         oe[i] = dio_oe;
         sclk = 1'b1;
         wait_clk(PH);
      end
      dio_in = 1'b1;
   endtask

   task automatic start_frame();
      stb = 1'b0;
      wait_clk(PH);
   endtask

   task automatic end_frame();
      stb = 1'b1;
      wait_clk(PH);
   endtask

   task automatic write_frame(input logic [7:0] q[$]);
      logic [7:0] rx, oe;
      start_frame();
      foreach (q[k]) bus_byte(q[k], 8, rx, oe);
      end_frame();
      model_frame(q);
      n_trans++;
      $display("txn %0d: write frame cmd %02h with %0d data bytes", n_trans, q[0], q.size() - 1);
      check_val("upd_count", upd_cnt, m_upd);
      check_val("display_on", display_on, m_on);
      check_val("brightness", brightness, m_bright);
   endtask

   task automatic read_frame(input logic [7:0] cmd, input int nread);
      logic [7:0]  rx, oe;
      logic [31:0] snap;
      logic [7:0]  q[$];
      start_frame();
      snap = keys;
      bus_byte(cmd, 8, rx, oe);
      for (int k = 0; k < nread; k++) begin
         keys = $urandom;                  // must not disturb the snapshot
         bus_byte(8'hFF, 8, rx, oe);
         check_val($sformatf("rd_byte%0d", k), rx, (k < 4) ? 32'(snap[8*k +: 8]) : 32'hFF);
         check_val($sformatf("rd_oe%0d", k), oe, (k < 4) ? 32'hFF : 32'h00);
      end
      end_frame();
      q.push_back(cmd);
      model_frame(q);
      n_trans++;
      $display("txn %0d: read frame cmd %02h, %0d bytes, snapshot %08h", n_trans, cmd, nread, snap);
      check_val("oe_after_frame", dio_oe, 1'b0);
      check_val("dio_after_frame", dio_out, 1'b1);
   endtask

   task automatic check_ram(input string tag);
      for (int a = 0; a < 16; a++) begin
         ram_raddr = 4'(a);
         wait_clk(1);
         check_val($sformatf("%s_ram%0d", tag, a), ram_rdata, m_ram[a]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] rx, oe, c;
      int kind, n;

      model_reset();
      wait_clk(3);
      check_val("rst_dio_out", dio_out, 1'b1);
      check_val("rst_dio_oe", dio_oe, 1'b0);
      check_val("rst_display_on", display_on, 1'b0);
      check_val("rst_brightness", brightness, 3'd0);
      check_val("rst_disp_upd", disp_upd, 1'b0);
      check_val("rst_ram_rdata", ram_rdata, 8'h00);
      rst_n = 1'b1;
      wait_clk(4);

      // Auto-increment write plus read latency
      q = {8'h40}; write_frame(q);
      q = {8'hC0, 8'h01, 8'h02, 8'h03}; write_frame(q);
      check_val("three_upd", upd_cnt, 3);
      ram_raddr = 4'd1;
      wait_clk(1);
      check_val("rdata_addr1", ram_rdata, 8'h02);
      ram_raddr = 4'd2;
      #2;
      check_val("rdata_latency", ram_rdata, 8'h02);
      wait_clk(1);
      check_val("rdata_addr2", ram_rdata, 8'h03);

      // Address wrap
      q = {8'h40}; write_frame(q);
      q = {8'hCE, 8'hAA, 8'hBB, 8'hCC}; write_frame(q);
      check_ram("wrap");

      // Fixed address and display control
      q = {8'h44}; write_frame(q);
      q = {8'hC5, 8'h11, 8'h22}; write_frame(q);
      q = {8'h8B}; write_frame(q);
      check_val("ctrl_on", display_on, 1'b1);
      check_val("ctrl_bright", brightness, 3'd3);
      check_ram("fixed");

      // Key read with trailing byte
      keys = 32'h44332211;
      read_frame(8'h42, 5);

      // Aborted data byte
      start_frame();
      bus_byte(8'hC3, 8, rx, oe);
      bus_byte(8'h5A, 5, rx, oe);
      end_frame();
      n_trans++;
      $display("txn %0d: address frame C3 aborted after 5 bits", n_trans);
      check_val("abort_upd", upd_cnt, m_upd);
      check_val("abort_oe", dio_oe, 1'b0);
      check_ram("abort");

      // Randomized frames
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 4);
         c = 8'($urandom);
         q = {};
         case (kind)
            0: begin q.push_back({2'b01, c[5:2], 1'b0, c[0]}); write_frame(q); end
            1: begin
               q.push_back({2'b11, c[5:0]});
               n = $urandom_range(1, 6);
               for (int k = 0; k < n; k++) q.push_back(8'($urandom));
               write_frame(q);
            end
            2: begin q.push_back({2'b10, c[5:0]}); write_frame(q); end
            3: begin keys = $urandom; read_frame({2'b01, c[5:2], 1'b1, c[0]}, $urandom_range(0, 5)); end
            default: begin
               q.push_back({2'b00, c[5:0]});
               q.push_back(8'($urandom));
               write_frame(q);
            end
         endcase
      end
      check_ram("random");

      // Reset in the middle of the second read byte
      keys = 32'hA5C3_0F96;
      start_frame();
      bus_byte(8'h42, 8, rx, oe);
      bus_byte(8'hFF, 8, rx, oe);
      bus_byte(8'hFF, 3, rx, oe);
      sclk = 1'b0;
      wait_clk(PH);
      check_val("pre_rst_oe", dio_oe, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_oe", dio_oe, 1'b0);
      check_val("midrst_dio", dio_out, 1'b1);
      stb = 1'b1;
      sclk = 1'b1;
      wait_clk(3);
      rst_n = 1'b1;
      model_reset();
      n_trans++;
      $display("txn %0d: reset asserted during read byte 1", n_trans);
      wait_clk(4);
      check_ram("post_rst");
      check_val("post_rst_on", display_on, 1'b0);
      keys = 32'h0BAD_F00D;
      read_frame(8'h42, 5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
